// File: rtl/multicycle_control.sv
// Multicycle MIPS control unit: Moore FSM that sequences fetch/decode/execute/memory/writeback.
// Optional feature: define MC_BNE_EN to add bne (opcode 000101) through the BRANCH state.
module multicycle_control (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       Zero,
   output logic [3:0] ALUctl,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic [1:0] PCSource,
   output logic       PCEn,
   output logic       illegal,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXEC   = 4'd6,
      ALUWB  = 4'd7,
      BRANCH = 4'd8,
      JUMP   = 4'd9,
      ADDIEX = 4'd10,
      ADDIWB = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
`ifdef MC_BNE_EN
   localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   // Returns {known, ALU code}; unknown functs fall back to ADD.
   function automatic logic [4:0] decode_funct(input logic [5:0] f);
      case (f)
         6'b100000: return {1'b1, ALU_ADD};
         6'b100010: return {1'b1, ALU_SUB};
         6'b100100: return {1'b1, ALU_AND};
         6'b100101: return {1'b1, ALU_OR};
         6'b101010: return {1'b1, ALU_SLT};
         6'b100111: return {1'b1, ALU_NOR};
         default:   return {1'b0, ALU_ADD};
      endcase
   endfunction

   state_t     state_q, state_d, cur_st;
   logic       funct_ok;
   logic [3:0] funct_alu;

   assign {funct_ok, funct_alu} = decode_funct(funct);

   // Reset makes the outputs look like FETCH immediately, before the clock edge lands.
   assign cur_st = rst_n ? state_q : FETCH;
   assign state  = state_q;

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignment for registered state avoids simulation races between processes.
      if (!rst_n) state_q <= FETCH;
      else        state_q <= state_d;
   end

   always_comb begin
      // NOTE: every output gets a default before the case, so no path can infer a latch.
      state_d  = FETCH;
      ALUctl   = ALU_ADD;
      ALUSrcA  = 1'b0;
      ALUSrcB  = 2'b00;
      IorD     = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      RegDst   = 1'b0;
      MemtoReg = 1'b0;
      PCSource = 2'b00;
      PCEn     = 1'b0;
      illegal  = 1'b0;

      unique case (cur_st)
         FETCH: begin
            MemRead = 1'b1;
            IRWrite = 1'b1;
            PCEn    = 1'b1;
            ALUSrcB = 2'b01;
            state_d = DECODE;
         end
         DECODE: begin
            ALUSrcB = 2'b11;
            case (opcode)
               OP_RTYPE:     state_d = EXEC;
               OP_LW, OP_SW: state_d = MEMADR;
               OP_BEQ:       state_d = BRANCH;
`ifdef MC_BNE_EN
               OP_BNE:       state_d = BRANCH;
`endif
               OP_J:         state_d = JUMP;
               OP_ADDI:      state_d = ADDIEX;
               default:      illegal = 1'b1;
            endcase
         end
         MEMADR, ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            if (cur_st == ADDIEX)     state_d = ADDIWB;
            else if (opcode == OP_LW) state_d = MEMRD;
            else                      state_d = MEMWR;
         end
         MEMRD: begin
            IorD    = 1'b1;
            MemRead = 1'b1;
            state_d = MEMWB;
         end
         MEMWB: begin
            MemtoReg = 1'b1;
            RegWrite = 1'b1;
         end
         MEMWR: begin
            IorD     = 1'b1;
            MemWrite = 1'b1;
         end
         EXEC: begin
            ALUSrcA = 1'b1;
            ALUctl  = funct_alu;
            if (funct_ok) state_d = ALUWB;
            else          illegal = 1'b1;
         end
         ALUWB: begin
            RegDst   = 1'b1;
            RegWrite = 1'b1;
         end
         ADDIWB: RegWrite = 1'b1;
         BRANCH: begin
            ALUSrcA  = 1'b1;
            ALUctl   = ALU_SUB;
            PCSource = 2'b01;
            PCEn     = Zero;
`ifdef MC_BNE_EN
            if (opcode == OP_BNE) PCEn = ~Zero;
`endif
         end
         JUMP: begin
            PCSource = 2'b10;
            PCEn     = 1'b1;
         end
         default: ;
      endcase

      if (!rst_n) begin
         PCEn     = 1'b0;
         MemRead  = 1'b0;
         MemWrite = 1'b0;
         IRWrite  = 1'b0;
         RegWrite = 1'b0;
         illegal  = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: an instruction-level model predicts every cycle's outputs.
// Compile with the same MC_BNE_EN setting as the RTL.
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] opcode, funct;
   logic       Zero;
   logic [3:0] ALUctl;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic       IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg;
   logic [1:0] PCSource;
   logic       PCEn, illegal;
   logic [3:0] state;

   always #5 clk = ~clk;

   multicycle_control dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .Zero(Zero),
      .ALUctl(ALUctl), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .IorD(IorD),
      .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
      .RegDst(RegDst), .MemtoReg(MemtoReg), .PCSource(PCSource), .PCEn(PCEn),
      .illegal(illegal), .state(state)
   );

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;

   typedef struct packed {
      logic [3:0] st;
      logic [3:0] alu_ctl;
      logic       src_a;
      logic [1:0] src_b;
      logic       iord, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg;
      logic [1:0] pc_source;
      logic       pc_en, illegal;
   } cyc_t;

   cyc_t want_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_checks++;
      if (obs !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, want);
      end
   endtask

   function automatic cyc_t blank(input logic [3:0] st);
      cyc_t c = '0;
      c.st      = st;
      c.alu_ctl = 4'b0010;
      return c;
   endfunction

   function automatic logic [4:0] r_alu(input logic [5:0] fn);
      case (fn)
         6'b100000: return 5'b1_0010;
         6'b100010: return 5'b1_0110;
         6'b100100: return 5'b1_0000;
         6'b100101: return 5'b1_0001;
         6'b101010: return 5'b1_0111;
         6'b100111: return 5'b1_1100;
         default:   return 5'b0_0010;
      endcase
   endfunction

   function automatic logic [21:0] observe();
      return {state, ALUctl, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite,
              RegWrite, RegDst, MemtoReg, PCSource, PCEn, illegal};
   endfunction

   // Expected per-cycle behaviour of one instruction, from fetch to its last cycle.
   task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z);
      cyc_t       c;
      logic [4:0] f;
      logic       bne_ok;
`ifdef MC_BNE_EN
      bne_ok = 1'b1;
`else
      bne_ok = 1'b0;
`endif
      want_q.delete();
      c = blank(0); c.mem_read = 1; c.ir_write = 1; c.pc_en = 1; c.src_b = 2'b01;
      want_q.push_back(c);
      c = blank(1); c.src_b = 2'b11;
      if (!(op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI} || (op == OP_BNE && bne_ok))) begin
         c.illegal = 1;
         want_q.push_back(c);
         return;
      end
      want_q.push_back(c);
      if (op == OP_LW || op == OP_SW || op == OP_ADDI) begin
         c = blank((op == OP_ADDI) ? 4'd10 : 4'd2); c.src_a = 1; c.src_b = 2'b10;
         want_q.push_back(c);
      end
      case (op)
         OP_LW: begin
            c = blank(3); c.iord = 1; c.mem_read = 1; want_q.push_back(c);
            c = blank(4); c.mem_to_reg = 1; c.reg_write = 1; want_q.push_back(c);
         end
         OP_SW: begin
            c = blank(5); c.iord = 1; c.mem_write = 1; want_q.push_back(c);
         end
         OP_ADDI: begin
            c = blank(11); c.reg_write = 1; want_q.push_back(c);
         end
         OP_R: begin
            f = r_alu(fn);
            c = blank(6); c.src_a = 1; c.alu_ctl = f[3:0]; c.illegal = ~f[4];
            want_q.push_back(c);
            if (f[4]) begin
               c = blank(7); c.reg_dst = 1; c.reg_write = 1; want_q.push_back(c);
            end
         end
         OP_J: begin
            c = blank(9); c.pc_source = 2'b10; c.pc_en = 1; want_q.push_back(c);
         end
         default: begin
            c = blank(8); c.src_a = 1; c.alu_ctl = 4'b0110; c.pc_source = 2'b01;
            c.pc_en = (op == OP_BNE) ? ~z : z;
            want_q.push_back(c);
         end
      endcase
   endtask

   task automatic check_cycle(input string name, input int i);
      logic [21:0] o, w;
      o = observe();
      w = want_q[i];
      check($sformatf("%s c%0d state", name, i), 32'(o[21:18]), 32'(w[21:18]));
      check($sformatf("%s c%0d outs", name, i), 32'(o[17:0]), 32'(w[17:0]));
   endtask

   // Entered anywhere inside a FETCH cycle; leaves at #1 after the edge into the next FETCH.
   task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                            input logic z, input int stop_at);
      build(op, fn, z);
      for (int i = 0; i < want_q.size() && i < stop_at; i++) begin
         opcode = (i == 0) ? 6'($urandom) : op;
         funct  = (i == 0) ? 6'($urandom) : fn;
         Zero   = (i == 2) ? z : 1'($urandom);
         #1;
         check_cycle(name, i);
         @(posedge clk); #1;
      end
   endtask

   task automatic reset_seq(input string name, input logic [3:0] cur_state);
      cyc_t        m;
      logic [21:0] o, w;
      m = blank(0); m.src_b = 2'b01;
      w = m;
      rst_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         opcode = 6'($urandom); funct = 6'($urandom); Zero = 1'($urandom);
         #1;
         o = observe();
         check($sformatf("%s rst%0d state", name, k), 32'(o[21:18]), (k == 0) ? 32'(cur_state) : 32'd0);
         check($sformatf("%s rst%0d outs", name, k), 32'(o[17:0]), 32'(w[17:0]));
         if (k < 2) begin @(posedge clk); #1; end
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   localparam logic [5:0] KNOWN_FN [6] = '{6'b100000, 6'b100010, 6'b100100,
                                           6'b100101, 6'b101010, 6'b100111};

   initial begin
      logic [5:0] op, fn;
      int         steps;
      rst_n = 1'b0; opcode = '0; funct = '0; Zero = 1'b0;
      @(posedge clk); #1;
      reset_seq("por", 4'd0);

      run_instr("lw",       OP_LW,   6'd0,      1'b0, 99);
      run_instr("sw",       OP_SW,   6'd0,      1'b0, 99);
      run_instr("sub",      OP_R,    6'b100010, 1'b0, 99);
      run_instr("slt",      OP_R,    6'b101010, 1'b1, 99);
      run_instr("addi",     OP_ADDI, 6'd5,      1'b0, 99);
      run_instr("beq_z1",   OP_BEQ,  6'd0,      1'b1, 99);
      run_instr("beq_z0",   OP_BEQ,  6'd0,      1'b0, 99);
      run_instr("j",        OP_J,    6'd0,      1'b1, 99);
      run_instr("bad_op",   6'b111111, 6'd0,    1'b0, 99);
      run_instr("bad_fn",   OP_R,    6'b000000, 1'b0, 99);
      run_instr("bne_z0",   OP_BNE,  6'd0,      1'b0, 99);
      run_instr("bne_z1",   OP_BNE,  6'd0,      1'b1, 99);

      // Abort an lw in MEMADR and in MEMWB.
      run_instr("lw_abort2", OP_LW, 6'd0, 1'b0, 2);
      reset_seq("mid_memadr", 4'd2);
      run_instr("lw_abort4", OP_LW, 6'd0, 1'b0, 4);
      reset_seq("mid_memwb", 4'd4);

      for (int n = 0; n < 300; n++) begin
         fn = KNOWN_FN[$urandom_range(0, 5)];
         case ($urandom_range(0, 9))
            0: op = OP_LW;
            1: op = OP_SW;
            2, 3: op = OP_R;
            4: op = OP_ADDI;
            5: op = OP_BEQ;
            6: op = OP_J;
            7: op = OP_BNE;
            8: op = 6'($urandom);
            default: begin op = OP_R; fn = 6'($urandom); end
         endcase
         if (n % 37 == 36) begin
            build(op, fn, 1'b0);
            steps = $urandom_range(1, want_q.size());
            run_instr($sformatf("rnd%0d_abort", n), op, fn, 1'($urandom), steps);
            build(op, fn, 1'b0);
            reset_seq($sformatf("rnd%0d_rst", n),
                      (steps < want_q.size()) ? want_q[steps].st : 4'd0);
         end else begin
            run_instr($sformatf("rnd%0d", n), op, fn, 1'($urandom), 99);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
